// File: rtl/addr_bus_responder_pkg.sv
// Shared types and constants for the address-bus responder.
//   state_e    : responder FSM states
//   op_e       : latched access direction
//   WAIT_CNT_W : width of the wait-state counter (supports 0..15 wait states)
//   is_req     : a request needs a window hit and exactly one of rd/wr low
package addr_bus_responder_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } op_e;

  // rd/wr are active-low; both low is illegal and is not a request.
  function automatic logic is_req(input logic hit, input logic rd_n, input logic wr_n);
    return hit && (rd_n ^ wr_n);
  endfunction

endpackage

// File: rtl/addr_bus_responder_if.sv
// Bus bundle between an initiator and the address-bus responder.
//   addr_in/addr_valid : address bus value and active-low "driven" flag
//   rd/wr              : active-low read/write requests
//   data_in            : write data from the data bus
//   data_out/data_en   : read data and active-high request to drive the data bus
//   ready              : active-high access complete
//   hit                : combinational window decode
// With ADDR_BUS_RESPONDER_WPROT_EN defined, adds wprot (active-low write protect)
// and wr_err (active-high, protected write completed without modifying RAM).
interface addr_bus_responder_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [WIDTH-1:0]      addr_in;
  logic                  addr_valid;
  logic                  rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_en;
  logic                  ready;
  logic                  hit;

`ifdef ADDR_BUS_RESPONDER_WPROT_EN
  logic                  wprot;
  logic                  wr_err;

  modport master (
    output addr_in, addr_valid, rd, wr, data_in, wprot,
    input  data_out, data_en, ready, hit, wr_err
  );

  modport slave (
    input  addr_in, addr_valid, rd, wr, data_in, wprot,
    output data_out, data_en, ready, hit, wr_err
  );
`else
  modport master (
    output addr_in, addr_valid, rd, wr, data_in,
    input  data_out, data_en, ready, hit
  );

  modport slave (
    input  addr_in, addr_valid, rd, wr, data_in,
    output data_out, data_en, ready, hit
  );
`endif

endinterface

// File: rtl/responder_ram.sv
// Single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_WIDTH, falling-edge clocked.
//   clk_i   : clock (write and registered read on the falling edge)
//   we_i    : write enable
//   re_i    : read enable; rdata_o updates on the same edge
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
// Contents are deliberately not reset.
module responder_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(negedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/addr_bus_responder.sv
// Memory-mapped responder on the far end of the address bus. Decodes a
// 2**DEPTH_LOG2-word window at BASE, inserts WAIT_STATES wait cycles, performs
// one RAM read or write and then holds ready until the initiator releases rd/wr.
// All state updates on the falling edge of clk_i.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (RAM contents are kept)
//   bus    : addr_bus_responder_if slave modport (address, rd/wr, data, ready, hit)
// Optional macro ADDR_BUS_RESPONDER_WPROT_EN adds the wprot/wr_err write protection.
module addr_bus_responder
  import addr_bus_responder_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DATA_WIDTH  = 8,
  parameter logic [WIDTH-1:0] BASE        = 16'h8000,
  parameter int unsigned      DEPTH_LOG2  = 8,
  parameter int unsigned      WAIT_STATES = 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  addr_bus_responder_if.slave bus
);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [DEPTH_LOG2-1:0]   off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    prot_q, prot_d;
  logic                    ready_q, ready_d;
  logic                    den_q, den_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;

  logic                    hit;
  logic                    released;
  logic                    prot_req;
  logic                    ram_we;
  logic                    ram_re;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  assign hit      = !bus.addr_valid &&
                    (bus.addr_in[WIDTH-1:DEPTH_LOG2] == BASE[WIDTH-1:DEPTH_LOG2]);
  assign released = bus.rd && bus.wr;

`ifdef ADDR_BUS_RESPONDER_WPROT_EN
  assign prot_req = !bus.wprot;
`else
  assign prot_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    prot_d  = prot_q;
    ready_d = ready_q;
    den_d   = den_q;
    dout_d  = dout_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_req(hit, bus.rd, bus.wr)) begin
          off_d   = bus.addr_in[DEPTH_LOG2-1:0];
          op_d    = bus.wr ? OpRead : OpWrite;
          wdata_d = bus.data_in;
          prot_d  = prot_req;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        // Abort wins over the final count so an abandoned write never reaches RAM.
        if (bus.addr_valid || released) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 1) begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        ram_we  = (op_q == OpWrite) && !prot_q;
        ram_re  = (op_q == OpRead);
        state_d = StDone;
      end
      StDone: begin
        if (released) begin
          state_d = StIdle;
          ready_d = 1'b0;
          den_d   = 1'b0;
        end else begin
          // ready registers one edge after entering DONE, giving N+WAIT_STATES+2.
          ready_d = 1'b1;
          den_d   = (op_q == OpRead);
          if (!ready_q && (op_q == OpRead)) begin
            dout_d = ram_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      off_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      prot_q  <= 1'b0;
      ready_q <= 1'b0;
      den_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      prot_q  <= prot_d;
      ready_q <= ready_d;
      den_q   <= den_d;
      dout_q  <= dout_d;
    end
  end

`ifdef ADDR_BUS_RESPONDER_WPROT_EN
  logic wr_err_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= ready_d && (op_q == OpWrite) && prot_q;
    end
  end

  assign bus.wr_err = wr_err_q;
`endif

  responder_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (off_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.hit      = hit;
  assign bus.ready    = ready_q;
  assign bus.data_en  = den_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_addr_bus_responder.sv
// Self-checking bench: one responder with WAIT_STATES=1 and one with WAIT_STATES=3
// share the same stimulus. Table-driven vectors plus hand-written sequences for
// reset mid-WAIT, abort during WAIT and (with the macro) write protection.
module tb_addr_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        valid_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  din;
  logic        wprot_n;

  int n_vec;
  int n_bad;
  logic [7:0] exp_q[$];

  addr_bus_responder_if #(.WIDTH(16), .DATA_WIDTH(8)) b1 ();
  addr_bus_responder_if #(.WIDTH(16), .DATA_WIDTH(8)) b3 ();

  assign b1.addr_in    = addr;
  assign b1.addr_valid = valid_n;
  assign b1.rd         = rd_n;
  assign b1.wr         = wr_n;
  assign b1.data_in    = din;
  assign b3.addr_in    = addr;
  assign b3.addr_valid = valid_n;
  assign b3.rd         = rd_n;
  assign b3.wr         = wr_n;
  assign b3.data_in    = din;
`ifdef ADDR_BUS_RESPONDER_WPROT_EN
  assign b1.wprot      = wprot_n;
  assign b3.wprot      = wprot_n;
`endif

  addr_bus_responder #(.WAIT_STATES(1)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b1.slave)
  );

  addr_bus_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Full accepted transaction; a read's expected data goes through the scoreboard.
  task automatic xact(input logic [15:0] a, input logic is_wr, input logic [7:0] d,
                      input logic [7:0] exp_rd);
    int lat1;
    int lat3;
    logic [7:0] e;
    @(posedge clk);
    addr = a; valid_n = 1'b0; rd_n = is_wr; wr_n = !is_wr; din = d;
    if (!is_wr) exp_q.push_back(exp_rd);
    #1;
    chk("hit", {15'd0, b1.hit}, 16'd1);
    lat1 = 0;
    lat3 = 0;
    for (int k = 1; k <= 20 && (lat1 == 0 || lat3 == 0); k++) begin
      @(negedge clk); #1;
      if (lat1 == 0 && b1.ready) lat1 = k;
      if (lat3 == 0 && b3.ready) lat3 = k;
    end
    chk("latency_ws1", 16'(lat1), 16'd4);
    chk("latency_ws3", 16'(lat3), 16'd6);
    chk("data_en_ws1", {15'd0, b1.data_en}, {15'd0, !is_wr});
    chk("data_en_ws3", {15'd0, b3.data_en}, {15'd0, !is_wr});
    if (!is_wr) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rdata_ws1", {8'd0, b1.data_out}, {8'd0, e});
        chk("rdata_ws3", {8'd0, b3.data_out}, {8'd0, e});
      end
    end
`ifdef ADDR_BUS_RESPONDER_WPROT_EN
    chk("wr_err_ws1", {15'd0, b1.wr_err}, {15'd0, is_wr && !wprot_n});
    chk("wr_err_ws3", {15'd0, b3.wr_err}, {15'd0, is_wr && !wprot_n});
`endif
    @(posedge clk);
    rd_n = 1'b1; wr_n = 1'b1; valid_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_clear", {14'd0, b1.ready, b3.ready}, 16'd0);
    chk("data_en_clear", {14'd0, b1.data_en, b3.data_en}, 16'd0);
`ifdef ADDR_BUS_RESPONDER_WPROT_EN
    chk("wr_err_clear", {14'd0, b1.wr_err, b3.wr_err}, 16'd0);
`endif
  endtask

  // Request that must never be accepted; hold it for 8 edges.
  task automatic no_xact(input logic [15:0] a, input logic v_n, input logic r_n,
                         input logic w_n, input logic exp_hit);
    logic seen;
    @(posedge clk);
    addr = a; valid_n = v_n; rd_n = r_n; wr_n = w_n; din = 8'hFF;
    #1;
    chk("hit", {15'd0, b1.hit}, {15'd0, exp_hit});
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (b1.ready || b3.ready || b1.data_en || b3.data_en) seen = 1'b1;
    end
    chk("never_ready", {15'd0, seen}, 16'd0);
    @(posedge clk);
    rd_n = 1'b1; wr_n = 1'b1; valid_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        valid_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  wdata;
    logic        exp_hit;
    logic        accept;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0; addr = 16'h0; valid_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    din = 8'h00; wprot_n = 1'b1;

    //          addr      v_n   rd_n  wr_n  wdata  hit   acc   exp_rd
    vecs[0]  = '{16'h8003, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{16'h8003, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5};
    vecs[2]  = '{16'h8000, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h00};
    vecs[3]  = '{16'h80FF, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, 8'h00};
    vecs[4]  = '{16'h8000, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11};
    vecs[5]  = '{16'h80FF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hEE};
    vecs[6]  = '{16'h7FFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{16'h8100, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{16'h8001, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00};
    vecs[9]  = '{16'h8001, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{16'h8001, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A};
    vecs[11] = '{16'h8003, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {14'd0, b1.ready, b3.ready}, 16'd0);
    chk("reset_data_en", {14'd0, b1.data_en, b3.data_en}, 16'd0);
    chk("reset_data_out", {b1.data_out, b3.data_out}, 16'd0);
    @(posedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].accept) begin
        xact(vecs[i].addr, !vecs[i].wr_n, vecs[i].wdata, vecs[i].exp_rd);
      end else begin
        no_xact(vecs[i].addr, vecs[i].valid_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].exp_hit);
      end
    end

    // Reset in the middle of WAIT drops the pending write.
    xact(16'h8010, 1'b1, 8'h00, 8'h00);
    @(posedge clk);
    addr = 16'h8010; valid_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; din = 8'h99;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_ready", {14'd0, b1.ready, b3.ready}, 16'd0);
    chk("midwait_reset_data_en", {14'd0, b1.data_en, b3.data_en}, 16'd0);
    chk("midwait_reset_data_out", {b1.data_out, b3.data_out}, 16'd0);
    rd_n = 1'b1; wr_n = 1'b1; valid_n = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;
    xact(16'h8010, 1'b0, 8'h00, 8'h00);

    // addr_valid raised during WAIT aborts the write; next request accepted at once.
    @(posedge clk);
    addr = 16'h80FF; valid_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; din = 8'h3C;
    @(negedge clk); #1;
    valid_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_ready", {14'd0, b1.ready, b3.ready}, 16'd0);
    xact(16'h80FF, 1'b0, 8'h00, 8'hEE);

`ifdef ADDR_BUS_RESPONDER_WPROT_EN
    xact(16'h8020, 1'b1, 8'h42, 8'h00);
    wprot_n = 1'b0;
    xact(16'h8020, 1'b1, 8'h77, 8'h00);
    wprot_n = 1'b1;
    xact(16'h8020, 1'b0, 8'h00, 8'h42);
`endif

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/addr_bus_responder.md
Name: addr_bus_responder

Overview:
- Memory-mapped responder on the far end of the address bus.
- Watches the address bus driven by address registers (PC, SP, etc.) and decodes a fixed window.
- Inserts programmable wait states, then performs a read or write to an internal RAM and signals completion.
- Drives read data toward the data bus with an enable, leaving bus muxing to the bus block.

Parameters:
- WIDTH, 16, address bus width in bits
- DATA_WIDTH, 8, data bus width in bits
- BASE, 16'h8000, first address of the decoded window; must be aligned to 2**DEPTH_LOG2
- DEPTH_LOG2, 8, log2 of window/RAM size in words
- WAIT_STATES, 1, extra clk cycles before access (0..15)

Ports:
- clk  input  1  system clock; all state updates on falling edge
- reset  input  1  asynchronous, active-low reset
- addr_in  input  WIDTH  address bus value
- addr_valid  input  1  active-low; address bus currently driven
- rd  input  1  active-low read request
- wr  input  1  active-low write request
- data_in  input  DATA_WIDTH  write data from data bus
- data_out  output  DATA_WIDTH  read data; always driven
- data_en  output  1  active-high; request to place data_out on bus
- ready  output  1  active-high; access complete
- hit  output  1  active-high, combinational; addr_in within window and addr_valid low

Behaviour:
- Reset, asynchronous, while low:
  - State goes to IDLE.
  - ready=0, data_en=0, data_out=0, wait counter=0.
  - RAM contents are not cleared.
- Window:
  - hit = !addr_valid && addr_in[WIDTH-1:DEPTH_LOG2] == BASE[WIDTH-1:DEPTH_LOG2].
  - offset = addr_in[DEPTH_LOG2-1:0].
- Request:
  - Valid request = hit && exactly one of rd/wr low.
  - rd and wr both low is illegal: ignored, state unchanged, nothing latched.
- States (falling edge):
  - IDLE:
    - On a valid request, latch offset, op (READ/WRITE) and data_in (write).
    - Load counter = WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT:
    - Decrement counter; when counter==1, go to ACCESS.
    - If addr_valid goes high, or rd and wr both high, abort to IDLE with no RAM change.
  - ACCESS:
    - WRITE: ram[offset] <= latched data.
    - READ: data_out <= ram[offset].
    - Go to DONE.
  - DONE:
    - ready=1; data_en=1 only for READ.
    - Hold until rd and wr both high, then go to IDLE, clearing ready and data_en on that edge.
- Latency:
  - Request sampled at edge N; ready high after edge N+WAIT_STATES+2.
  - WAIT_STATES=0 gives ready after N+2.
- Address/data changes after latching are ignored until IDLE; the latched values govern.
- New requests are not accepted in WAIT/ACCESS/DONE; the initiator must release rd/wr first. Back-to-back accesses need one IDLE edge between them.
- Reset asserted mid-operation:
  - Immediate IDLE; the pending write is dropped.
  - A write already completed in ACCESS persists.
- Offset wraps naturally within the window; there is no carry into out-of-window addresses.

Optional Feature:
- Macro: ADDR_BUS_RESPONDER_WPROT_EN.
- Defined:
  - Adds input wprot (1 bit, active-low) and output wr_err (1 bit, active-high).
  - wprot is sampled at latch time in IDLE.
  - A protected WRITE proceeds through WAIT/ACCESS/DONE with identical timing, but RAM is unmodified.
  - wr_err=1 while in DONE for that access; cleared on return to IDLE and on reset.
- Undefined: neither port exists; all writes modify RAM.

Decomposition:
- Package addr_bus_responder_pkg:
  - State encoding (IDLE, WAIT, ACCESS, DONE).
  - Op encoding (OP_READ, OP_WRITE).
  - Counter width constant WAIT_CNT_W=4.
- Sub-module responder_ram:
  - Single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_WIDTH, falling-edge write/read.
  - Instantiated once.

Test Plan:
- Reset low mid-WAIT of a write to 16'h8010 (WAIT_STATES=1, ram[8'h10] preloaded 8'h00) -> ready=0, data_en=0 immediately; later read of 16'h8010 returns 8'h00.
- Write 8'hA5 to 16'h8003 (WAIT_STATES=1), then read 16'h8003 -> ready after 3 edges each; read data_out=8'hA5, data_en=1; write leaves data_en=0.
- Read 16'h7FFF and 16'h8100 -> hit=0, ready never asserts, state remains IDLE.
- rd and wr both low at 16'h8001 -> ignored; ram[8'h01] unchanged, ready=0.
- WAIT_STATES=3: addr_valid raised during WAIT of a write of 8'h3C to 16'h80FF -> abort, ready never asserts, ram[8'hFF] unchanged; a new request is accepted on the next edge.
- With ADDR_BUS_RESPONDER_WPROT_EN, wprot=0: write 8'h77 to 16'h8020 -> ready and wr_err asserted in DONE; subsequent read returns the prior value.
